// File: rtl/rd_hazard_forward_unit.sv
// Destination-register tracker for EX/MEM/WB with operand forwarding selects and load-use stall.
// Define HAZARD_WB_FWD_EN to let WB-stage matches forward (select 11); otherwise WB is never matched.
module rd_hazard_forward_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_r1,
    input  logic [4:0]       id_r2,
    input  logic             id_r1_used,
    input  logic             id_r2_used,
    input  logic [4:0]       id_rd,
    input  logic             id_rf_le,
    input  logic             id_load,
    input  logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic [4:0]       wb_rd,
    output logic             wb_le,
    output logic [CNT_W-1:0] stall_cnt
);

    // The load flag only matters in EX; past EX the data is available, so it is not carried on.
    logic [4:0]       ex_rd_q, ex_rd_d;
    logic             ex_le_q, ex_le_d;
    logic             ex_load_q, ex_load_d;
    logic [4:0]       mem_rd_q, mem_rd_d;
    logic             mem_le_q, mem_le_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic             wb_le_q, wb_le_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic ex_hit_a, ex_hit_b;
    logic mem_hit_a, mem_hit_b;
    logic wb_hit_a, wb_hit_b;

    function automatic logic hit(input logic le, input logic [4:0] rd,
                                 input logic [4:0] src, input logic used);
        return le && (rd == src) && (src != 5'd0) && used;
    endfunction

    always_comb begin
        ex_hit_a  = hit(ex_le_q, ex_rd_q, id_r1, id_r1_used);
        ex_hit_b  = hit(ex_le_q, ex_rd_q, id_r2, id_r2_used);
        mem_hit_a = hit(mem_le_q, mem_rd_q, id_r1, id_r1_used);
        mem_hit_b = hit(mem_le_q, mem_rd_q, id_r2, id_r2_used);
`ifdef HAZARD_WB_FWD_EN
        wb_hit_a  = hit(wb_le_q, wb_rd_q, id_r1, id_r1_used);
        wb_hit_b  = hit(wb_le_q, wb_rd_q, id_r2, id_r2_used);
`else
        wb_hit_a  = 1'b0;
        wb_hit_b  = 1'b0;
`endif
    end

    always_comb begin
        stall = ex_load_q && (ex_hit_a || ex_hit_b);

        // Youngest producer wins; a load still in EX has no data yet, so fall back to 00.
        fwd_a = 2'b00;
        if (ex_hit_a) begin
            fwd_a = ex_load_q ? 2'b00 : 2'b01;
        end else if (mem_hit_a) begin
            fwd_a = 2'b10;
        end else if (wb_hit_a) begin
            fwd_a = 2'b11;
        end

        fwd_b = 2'b00;
        if (ex_hit_b) begin
            fwd_b = ex_load_q ? 2'b00 : 2'b01;
        end else if (mem_hit_b) begin
            fwd_b = 2'b10;
        end else if (wb_hit_b) begin
            fwd_b = 2'b11;
        end
    end

    always_comb begin
        ex_rd_d   = id_rd;
        ex_le_d   = id_rf_le;
        ex_load_d = id_load;
        if (stall || flush) begin
            ex_rd_d   = 5'd0;
            ex_le_d   = 1'b0;
            ex_load_d = 1'b0;
        end
        mem_rd_d = ex_rd_q;
        mem_le_d = ex_le_q;
        wb_rd_d  = mem_rd_q;
        wb_le_d  = mem_le_q;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rd_q     <= 5'd0;
            ex_le_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            mem_rd_q    <= 5'd0;
            mem_le_q    <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_le_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_rd_q     <= ex_rd_d;
            ex_le_q     <= ex_le_d;
            ex_load_q   <= ex_load_d;
            mem_rd_q    <= mem_rd_d;
            mem_le_q    <= mem_le_d;
            wb_rd_q     <= wb_rd_d;
            wb_le_q     <= wb_le_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign wb_rd     = wb_rd_q;
    assign wb_le     = wb_le_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_rd_hazard_forward_unit.sv
// Scoreboard bench for rd_hazard_forward_unit: directed test-plan cases followed by random traffic.
// Expected values come from an issue-history model; honours HAZARD_WB_FWD_EN like the design.
module tb_rd_hazard_forward_unit;

    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_r1, id_r2, id_rd;
    logic             id_r1_used, id_r2_used, id_rf_le, id_load, flush;
    logic [1:0]       fwd_a, fwd_b;
    logic             stall;
    logic [4:0]       wb_rd;
    logic             wb_le;
    logic [CNT_W-1:0] stall_cnt;

    rd_hazard_forward_unit #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .id_r1      (id_r1),
        .id_r2      (id_r2),
        .id_r1_used (id_r1_used),
        .id_r2_used (id_r2_used),
        .id_rd      (id_rd),
        .id_rf_le   (id_rf_le),
        .id_load    (id_load),
        .flush      (flush),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .stall      (stall),
        .wb_rd      (wb_rd),
        .wb_le      (wb_le),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rd;
        logic       le;
        logic       load;
    } issued_t;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       st;
        logic [4:0] wrd;
        logic       wle;
        int         cnt;
    } exp_t;

    // hist[k] = instruction issued k+1 cycles ago (producer distance k+1).
    issued_t hist[3];
    int      stalls_seen;
    exp_t    sb[$];
    int      errors = 0;
    int      checks = 0;

    function automatic logic [1:0] select_for(input logic [4:0] r, input logic used,
                                              output logic load_use);
        load_use = 1'b0;
        if (!used || r == 5'd0) return 2'b00;
        for (int d = 1; d <= 3; d++) begin
            if (hist[d-1].le && hist[d-1].rd == r) begin
                if (d == 1 && hist[0].load) begin
                    load_use = 1'b1;
                    return 2'b00;
                end
`ifndef HAZARD_WB_FWD_EN
                if (d == 3) return 2'b00;
`endif
                return 2'(d);
            end
        end
        return 2'b00;
    endfunction

    task automatic step(input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic le, input logic ld,
                        input logic fl, input logic rst);
        exp_t    e;
        logic    lu_a, lu_b;
        issued_t nxt;
        @(posedge clk);
        #1;
        id_r1 = r1; id_r2 = r2; id_r1_used = u1; id_r2_used = u2;
        id_rd = rd; id_rf_le = le; id_load = ld; flush = fl; reset = rst;
        e.fa  = select_for(r1, u1, lu_a);
        e.fb  = select_for(r2, u2, lu_b);
        e.st  = lu_a | lu_b;
        e.wrd = hist[2].rd;
        e.wle = hist[2].le;
        e.cnt = (stalls_seen > CNT_MAX) ? CNT_MAX : stalls_seen;
        sb.push_back(e);
        // Advance the model to what the coming edge will commit.
        if (rst) begin
            for (int k = 0; k < 3; k++) hist[k] = '0;
            stalls_seen = 0;
        end else begin
            nxt = (e.st || fl) ? issued_t'(0) : issued_t'({rd, le, ld});
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = nxt;
            if (e.st) stalls_seen++;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are combinational/registered every cycle, so each cycle is a response.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("fwd_a", int'(fwd_a), int'(e.fa));
            chk("fwd_b", int'(fwd_b), int'(e.fb));
            chk("stall", int'(stall), int'(e.st));
            chk("wb_rd", int'(wb_rd), int'(e.wrd));
            chk("wb_le", int'(wb_le), int'(e.wle));
            chk("stall_cnt", int'(stall_cnt), e.cnt);
        end
    end

    task automatic nop();
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        id_r1 = '0; id_r2 = '0; id_r1_used = 0; id_r2_used = 0;
        id_rd = '0; id_rf_le = 0; id_load = 0; flush = 0; reset = 1'b1;
        for (int k = 0; k < 3; k++) hist[k] = '0;
        stalls_seen = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state with hazard-looking ID inputs.
        step(5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        // EX forward of r5.
        step(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        nop(); nop(); nop();
        // Load-use on r7, consumer held for a second cycle.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        step(5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Priority: r3 in MEM and EX.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        step(5'd3, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // GR0 writes in all stages.
        repeat (3) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // WB distance for r9.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        nop(); nop();
        step(5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Flushed producer of r4.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        step(5'd4, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Reset with pending entries.
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        step(5'd6, 5'd6, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        step(5'd6, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Saturate the counter with 20 load-use stalls, flush on some stall cycles.
        for (int i = 0; i < 20; i++) begin
            step(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
            step(5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'(i % 3 == 0), 1'b0);
        end
        nop();
        // Random traffic over a small register window so hazards are frequent.
        for (int i = 0; i < 600; i++) begin
            step(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
                 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 60) == 0));
        end

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
